// File: rtl/brq_tcm_pkg.sv
// Shared types and helpers for the Buraq-mini multi-port tightly coupled memory controller.
// Holds load/store size codes, the response pipeline record and the size/extension helpers.
package brq_tcm_pkg;

  localparam int DATA_W    = 32;
  localparam int MAX_PORTS = 4;

  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } ls_size_e;

  typedef struct packed {
    logic              valid;
    logic [1:0]        port;
    logic              err;
    logic [2:0]        size;
    logic [1:0]        offset;
    logic [DATA_W-1:0] word;
  } tcm_pipe_t;

  // Unsigned sizes only make sense for loads.
  function automatic logic size_legal(input logic [2:0] size, input logic we);
    case (size)
      LS_B, LS_H, LS_W: return 1'b1;
      LS_BU, LS_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] offset);
    case (size)
      LS_H, LS_HU: return offset[0];
      LS_W:        return offset != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] load_extend(input logic [2:0]        size,
                                                    input logic [1:0]        offset,
                                                    input logic [DATA_W-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    case (size)
      LS_B:    return {{(DATA_W-8){b[7]}}, b};
      LS_BU:   return {{(DATA_W-8){1'b0}}, b};
      LS_H:    return {{(DATA_W-16){h[15]}}, h};
      LS_HU:   return {{(DATA_W-16){1'b0}}, h};
      LS_W:    return word;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/brq_tcm_ctrl_arbiter.sv
// Round-robin arbiter: grants the first requesting port at or after rr_ptr, then
// moves rr_ptr just past the winner.
module brq_rr_arbiter #(
  parameter int  NUM_PORTS = 2,
  localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PW-1:0]        grant_idx,
  output logic                 grant_any
);
  import brq_tcm_pkg::*;

  logic [PW-1:0] rr_ptr;

  function automatic logic [PW-1:0] slot(input logic [PW-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return PW'(s);
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!grant_any && req[slot(rr_ptr, i)]) begin
        grant_idx = slot(rr_ptr, i);
        grant_any = 1'b1;
      end
    end
    grant[grant_idx] = grant_any;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= '0;
    else if (grant_any)
      rr_ptr <= (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + PW'(1);
  end

endmodule

// File: rtl/brq_tcm_ctrl.sv
// Multi-port TCM controller: arbitrates NUM_PORTS requestors onto one word SRAM,
// writes byte lanes at acceptance and returns extended load data READ_LAT cycles later.
module brq_tcm_ctrl #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 15,
  parameter int NUM_PORTS = 2,
  parameter int READ_LAT  = 1
) (
  input  logic                                brq_clk,
  input  logic                                brq_rst,
  input  logic [NUM_PORTS-1:0]                req_valid,
  output logic [NUM_PORTS-1:0]                req_ready,
  input  logic [NUM_PORTS-1:0]                req_we,
  input  logic [NUM_PORTS-1:0][2:0]           req_size,
  input  logic [NUM_PORTS-1:0][AddrWidth-1:0] req_addr,
  input  logic [NUM_PORTS-1:0][DataWidth-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]                rsp_valid,
  output logic [NUM_PORTS-1:0][DataWidth-1:0] rsp_rdata,
  output logic [NUM_PORTS-1:0]                rsp_err
);
  import brq_tcm_pkg::*;

  localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int IW    = AddrWidth - 2;
  localparam int DEPTH = 2 ** IW;

  logic [NUM_PORTS-1:0] grant;
  logic [PW-1:0]        gidx;
  logic                 gany;
  logic                 accept;

  brq_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk       (brq_clk),
    .rst       (brq_rst),
    .req       (req_valid),
    .grant     (grant),
    .grant_idx (gidx),
    .grant_any (gany)
  );

  // Nothing is accepted while reset is asserted, so no response can leak past it.
  assign accept    = gany & ~brq_rst;
  assign req_ready = brq_rst ? '0 : grant;

  logic                 sel_we;
  logic [2:0]           sel_size;
  logic [AddrWidth-1:0] sel_addr;
  logic [DataWidth-1:0] sel_wdata;
  logic                 sel_err;
  logic [IW-1:0]        widx;

  assign sel_we    = req_we[gidx];
  assign sel_size  = req_size[gidx];
  assign sel_addr  = req_addr[gidx];
  assign sel_wdata = req_wdata[gidx];
  assign sel_err   = !size_legal(sel_size, sel_we) || is_misaligned(sel_size, sel_addr[1:0]);
  assign widx      = sel_addr[AddrWidth-1:2];

  logic [3:0]           be;
  logic [DataWidth-1:0] wword;

  always_comb begin
    be    = '0;
    wword = sel_wdata;
    case (sel_size)
      LS_B: begin
        be[sel_addr[1:0]] = 1'b1;
        wword = {4{sel_wdata[7:0]}};
      end
      LS_H: begin
        be    = sel_addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{sel_wdata[15:0]}};
      end
      LS_W:    be = 4'b1111;
      default: be = '0;
    endcase
    if (!(accept && sel_we && !sel_err)) be = '0;
  end

  logic [DataWidth-1:0] mem [DEPTH];

  always_ff @(posedge brq_clk) begin
    for (int l = 0; l < 4; l++)
      if (be[l]) mem[widx][8*l +: 8] <= wword[8*l +: 8];
  end

  // Stage p0 captures the accepted request and the SRAM word; later stages only delay it.
  tcm_pipe_t pipe_p [READ_LAT];

  always_ff @(posedge brq_clk) begin
    pipe_p[0].valid  <= accept;
    pipe_p[0].port   <= 2'(gidx);
    pipe_p[0].err    <= sel_err;
    pipe_p[0].size   <= sel_size;
    pipe_p[0].offset <= sel_addr[1:0];
    pipe_p[0].word   <= (sel_we || sel_err) ? '0 : mem[widx];
    for (int i = 1; i < READ_LAT; i++) pipe_p[i] <= pipe_p[i-1];
    if (brq_rst)
      for (int i = 0; i < READ_LAT; i++) pipe_p[i].valid <= 1'b0;
  end

  // Output stage: stores and errors carry a zero word, so their extended data is zero.
  tcm_pipe_t last_p;
  assign last_p = pipe_p[READ_LAT-1];

  always_comb begin
    rsp_valid = '0;
    rsp_err   = '0;
    rsp_rdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (last_p.valid && last_p.port == 2'(p)) begin
        rsp_valid[p] = 1'b1;
        rsp_err[p]   = last_p.err;
        rsp_rdata[p] = load_extend(last_p.size, last_p.offset, last_p.word);
      end
    end
  end

endmodule

// File: tb/tb_brq_tcm_ctrl.sv
// Directed bench for brq_tcm_ctrl with two ports and a three-cycle response latency.
module tb_brq_tcm_ctrl;
  localparam int NP  = 2;
  localparam int LAT = 3;
  localparam int AW  = 15;
  localparam int DW  = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NP-1:0]        req_valid, req_ready, req_we, rsp_valid, rsp_err;
  logic [NP-1:0][2:0]   req_size;
  logic [NP-1:0][AW-1:0] req_addr;
  logic [NP-1:0][DW-1:0] req_wdata, rsp_rdata;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  brq_tcm_ctrl #(.DataWidth(DW), .AddrWidth(AW), .NUM_PORTS(NP), .READ_LAT(LAT)) dut (
    .brq_clk   (clk),
    .brq_rst   (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic we, input logic [2:0] sz,
                       input logic [AW-1:0] a, input logic [31:0] wd);
    req_valid[p] = 1'b1;
    req_we[p]    = we;
    req_size[p]  = sz;
    req_addr[p]  = a;
    req_wdata[p] = wd;
  endtask

  // One isolated transaction: acceptance, quiet latency window, single response pulse.
  task automatic xact(input string tag, input int p, input logic we, input logic [2:0] sz,
                      input logic [AW-1:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_d, input logic exp_e);
    int n;
    n = 0;
    drive(p, we, sz, a, wd);
    #1;
    while (!req_ready[p] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/ready"}, 32'(req_ready), 32'(1 << p));
    @(posedge clk);
    #1;
    req_valid[p] = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      check({tag, "/early"}, 32'(rsp_valid), 32'd0);
    end
    @(negedge clk);
    check({tag, "/valid"}, 32'(rsp_valid), 32'(1 << p));
    check({tag, "/rdata"}, rsp_rdata[p], exp_d);
    check({tag, "/err"}, 32'(rsp_err), exp_e ? 32'(1 << p) : 32'd0);
    check({tag, "/other"}, rsp_rdata[1-p], 32'd0);
    @(negedge clk);
    check({tag, "/pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_size = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst/valid", 32'(rsp_valid), 32'd0);
    check("rst/err", 32'(rsp_err), 32'd0);
    check("rst/rdata0", rsp_rdata[0], 32'd0);
    check("rst/rdata1", rsp_rdata[1], 32'd0);
    check("rst/ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    xact("sw10",    0, 1'b1, 3'b010, 15'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    xact("lw10",    0, 1'b0, 3'b010, 15'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    xact("lb13",    0, 1'b0, 3'b000, 15'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    xact("lbu13",   0, 1'b0, 3'b100, 15'h13, 32'h0, 32'h000000DE, 1'b0);
    xact("lh12",    0, 1'b0, 3'b001, 15'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
    xact("lhu10",   0, 1'b0, 3'b101, 15'h10, 32'h0, 32'h0000BEEF, 1'b0);
    xact("sh11mis", 0, 1'b1, 3'b001, 15'h11, 32'h1234, 32'h0, 1'b1);
    xact("lw10b",   0, 1'b0, 3'b010, 15'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    xact("ld011",   0, 1'b0, 3'b011, 15'h10, 32'h0, 32'h0, 1'b1);
    xact("sw20",    1, 1'b1, 3'b010, 15'h20, 32'hCAFEF00D, 32'h0, 1'b0);
    xact("sb21",    1, 1'b1, 3'b000, 15'h21, 32'hFFFFFFA5, 32'h0, 1'b0);
    xact("sh22",    1, 1'b1, 3'b001, 15'h22, 32'hABCD1234, 32'h0, 1'b0);
    xact("lw20",    1, 1'b0, 3'b010, 15'h20, 32'h0, 32'h1234A50D, 1'b0);
    xact("lh20",    1, 1'b0, 3'b001, 15'h20, 32'h0, 32'hFFFFA50D, 1'b0);
    xact("lhu22",   1, 1'b0, 3'b101, 15'h22, 32'h0, 32'h00001234, 1'b0);
    xact("lb21",    1, 1'b0, 3'b000, 15'h21, 32'h0, 32'hFFFFFFA5, 1'b0);
    xact("sbu20",   1, 1'b1, 3'b100, 15'h20, 32'hFFFFFFFF, 32'h0, 1'b1);
    xact("lw12mis", 0, 1'b0, 3'b010, 15'h12, 32'h0, 32'h0, 1'b1);
    xact("lhu13mis",0, 1'b0, 3'b101, 15'h13, 32'h0, 32'h0, 1'b1);
    xact("lw20b",   1, 1'b0, 3'b010, 15'h20, 32'h0, 32'h1234A50D, 1'b0);

    // Back-to-back loads from port 1 in cycles 0,1,2; responses in cycles 3,4,5.
    drive(1, 1'b0, 3'b010, 15'h10, 32'h0);
    #1;
    check("burst/ready0", 32'(req_ready), 32'h2);
    check("burst/quiet0", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    drive(1, 1'b0, 3'b010, 15'h20, 32'h0);
    @(negedge clk);
    check("burst/ready1", 32'(req_ready), 32'h2);
    check("burst/quiet1", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    drive(1, 1'b0, 3'b000, 15'h13, 32'h0);
    @(negedge clk);
    check("burst/ready2", 32'(req_ready), 32'h2);
    check("burst/quiet2", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("burst/v3", 32'(rsp_valid), 32'h2);
    check("burst/d3", rsp_rdata[1], 32'hDEADBEEF);
    @(negedge clk);
    check("burst/v4", 32'(rsp_valid), 32'h2);
    check("burst/d4", rsp_rdata[1], 32'h1234A50D);
    @(negedge clk);
    check("burst/v5", 32'(rsp_valid), 32'h2);
    check("burst/d5", rsp_rdata[1], 32'hFFFFFFDE);
    @(negedge clk);
    check("burst/v6", 32'(rsp_valid), 32'd0);

    // Two loads in flight from port 0, then reset: both responses must vanish.
    drive(0, 1'b0, 3'b010, 15'h10, 32'h0);
    @(posedge clk); #1;
    drive(0, 1'b0, 3'b010, 15'h20, 32'h0);
    @(posedge clk); #1;
    req_valid = '0;
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rstflight/valid", 32'(rsp_valid), 32'd0);
      if (k == 1) begin
        check("rstflight/rdata0", rsp_rdata[0], 32'd0);
        rst = 1'b0;
      end
    end

    // Both ports request continuously: grants 0,1,0,1 from port 0, one response per cycle.
    drive(0, 1'b0, 3'b010, 15'h10, 32'h0);
    drive(1, 1'b0, 3'b010, 15'h20, 32'h0);
    for (int i = 0; i < 10; i++) begin
      if (i == 6) req_valid = '0;
      #1;
      if (i < 6) check("alt/ready", 32'(req_ready), (i % 2 == 1) ? 32'h2 : 32'h1);
      else       check("alt/idle", 32'(req_ready), 32'd0);
      if (i >= LAT && i < 6 + LAT) begin
        if ((i - LAT) % 2 == 0) begin
          check("alt/v0", 32'(rsp_valid), 32'h1);
          check("alt/d0", rsp_rdata[0], 32'hDEADBEEF);
          check("alt/z1", rsp_rdata[1], 32'd0);
        end else begin
          check("alt/v1", 32'(rsp_valid), 32'h2);
          check("alt/d1", rsp_rdata[1], 32'h1234A50D);
          check("alt/z0", rsp_rdata[0], 32'd0);
        end
      end else begin
        check("alt/quiet", 32'(rsp_valid), 32'd0);
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/brq_tcm_ctrl.md
Name: brq_tcm_ctrl

Overview:
- Multi-port tightly coupled data memory controller for the Buraq-mini core family; successor to the single-port dccm.
- NUM_PORTS requestors share one word-organised SRAM: core load/store unit, debug/loader, and optional DMA.
- Adds a valid/ready request handshake, round-robin arbitration, and a parametrised read latency.
- Adds load sign/zero extension and misalignment error reporting.

Parameters:
- DataWidth, 32, data word width; fixed at 32 for RV32.
- AddrWidth, 15, byte address width; memory depth = 2^(AddrWidth-2) words.
- NUM_PORTS, 2, number of requestor channels (1..4).
- READ_LAT, 1, cycles from request acceptance to response (1..4).

Ports:
- brq_clk  input  1  clock; all logic on rising edge.
- brq_rst  input  1  synchronous active-high reset.
- req_valid  input  [NUM_PORTS]  request present.
- req_ready  output  [NUM_PORTS]  request accepted this cycle.
- req_we  input  [NUM_PORTS]  1 = store, 0 = load.
- req_size  input  [NUM_PORTS][3]  RISC-V funct3 size code.
- req_addr  input  [NUM_PORTS][AddrWidth]  byte address.
- req_wdata  input  [NUM_PORTS][DataWidth]  store data, LSB-aligned.
- rsp_valid  output  [NUM_PORTS]  one-cycle response pulse.
- rsp_rdata  output  [NUM_PORTS][DataWidth]  extended load data; 0 for stores and errors.
- rsp_err  output  [NUM_PORTS]  misaligned or illegal size.

Behaviour:
- Reset: rr_ptr=0, response pipeline cleared, rsp_valid=0, rsp_rdata=0, rsp_err=0. SRAM contents are not reset.
- Reset mid-operation: all in-flight responses are dropped; no rsp_valid is issued for them.
- Arbitration: combinational. Among asserted req_valid, grant the first index at or after rr_ptr, wrapping modulo NUM_PORTS. req_ready is high only for the granted port; at most one grant per cycle.
- rr_ptr update: after a grant to port g, rr_ptr <= (g+1) mod NUM_PORTS. With no grant, rr_ptr holds.
- Requestor stability: the requestor must hold all req_* fields stable while req_valid=1 and req_ready=0.
- Size codes: 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - Stores accept only 000/001/010.
  - Any other code is illegal and sets rsp_err.
- Misalignment: H/HU with addr[0]=1, or W with addr[1:0]!=0, sets rsp_err.
- Errored requests: no SRAM write; rsp_rdata=0.
- Stores: byte lanes are written at the acceptance edge.
  - B: lane addr[1:0] gets wdata[7:0].
  - H: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - W: all four lanes.
- Loads: the word is read at acceptance. The lane is selected by addr[1:0], then:
  - B/H are sign-extended.
  - BU/HU are zero-extended.
  - W is passed through.
- Latency: every accepted request, load, store or error, produces exactly one rsp_valid pulse on its own port exactly READ_LAT cycles after the acceptance edge.
- Pipeline: READ_LAT-deep shift register carrying {valid, port, err, size, offset, word}. It is fully pipelined at one request per cycle, so no back-pressure on responses.
- Ordering: a store accepted in cycle t is visible to a load accepted in cycle t+1 or later. A store and a load cannot occur in the same cycle (single grant).
- Port isolation: rsp_valid of non-target ports stays 0. rsp_rdata/rsp_err of idle ports hold 0.

Decomposition:
- Shared package brq_tcm_pkg:
  - enum ls_size_e: LS_B=3'b000, LS_H=3'b001, LS_W=3'b010, LS_BU=3'b100, LS_HU=3'b101.
  - struct tcm_pipe_t: valid, port, err, size, offset[1:0], word.
  - function is_misaligned(size, offset).
  - function load_extend(size, offset, word).
- Sub-module brq_rr_arbiter, parametrised by NUM_PORTS: req vector in; grant one-hot and grant index out; owns rr_ptr.
- Top level holds the SRAM array, byte-lane write logic, and the response pipeline.

Test Plan:
- Port0 SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_valid[0] READ_LAT cycles after each acceptance; second response has rdata=0xDEADBEEF, err=0.
- After the word above: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
- SH 0x1234 @0x11 -> rsp_err=1, rdata=0; subsequent LW @0x10 still returns 0xDEADBEEF. Size 3'b011 load -> rsp_err=1.
- Both ports assert valid continuously with NUM_PORTS=2 -> grants alternate 0,1,0,1 starting from port 0 after reset; one response per cycle in steady state.
- READ_LAT=3: back-to-back loads from port1 at cycles 0,1,2 -> rsp_valid[1] at cycles 3,4,5 with matching data order.
- Assert brq_rst with 2 loads in flight -> no rsp_valid for them; post-reset grant starts at port 0; SRAM data written before reset is still readable.
